// File: rtl/pwm_glow_pkg.sv
// Shared encodings for the multi-channel PWM glow driver.
package pwm_glow_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_FIXED   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/pwm_glow_channel.sv
// One LED channel: pending/active configuration, breathing ramp and the
// registered LED compare against the shared PWM counter.
module pwm_glow_channel
  import pwm_glow_pkg::*;
#(
  parameter int PWM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  mode_t                wr_mode,
  input  logic [PWM_WIDTH-1:0] wr_duty,
  input  logic                 boundary,
  input  logic                 step,
  input  logic [PWM_WIDTH-1:0] cnt,
  output logic                 led
);

  mode_t                mode_p;
  logic [PWM_WIDTH-1:0] duty_p;
  logic                 dirty;

  mode_t                mode;
  logic [PWM_WIDTH-1:0] peak;
  logic [PWM_WIDTH-1:0] level;
  logic                 dir;

  mode_t                nxt_mode_p;
  logic [PWM_WIDTH-1:0] nxt_duty_p;
  logic                 upd;
  mode_t                eff_mode;
  logic [PWM_WIDTH-1:0] eff_peak;
  logic [PWM_WIDTH-1:0] level_n;
  logic [PWM_WIDTH-1:0] peak_n;
  logic                 dir_n;

  // Pending set as seen at this edge; a write on the boundary cycle is folded
  // in here so it reaches the active set at the same edge.
  always_comb begin
    nxt_mode_p = wr ? wr_mode : mode_p;
    nxt_duty_p = wr ? wr_duty : duty_p;
    upd        = wr | dirty;
    eff_mode   = upd ? nxt_mode_p : mode;
    eff_peak   = upd ? nxt_duty_p : peak;
  end

  // Active-set update applied at a boundary edge: config transfer first,
  // then a ramp step if the channel keeps breathing without being clamped.
  always_comb begin
    level_n = level;
    peak_n  = peak;
    dir_n   = dir;
    case (eff_mode)
      MODE_FIXED: begin
        if (upd) level_n = nxt_duty_p;
      end
      MODE_BREATHE: begin
        peak_n = eff_peak;
        if (mode != MODE_BREATHE) begin
          level_n = '0;
          dir_n   = DIR_UP;
        end else if (level > eff_peak) begin
          level_n = eff_peak;
          dir_n   = DIR_DN;
        end else if (step) begin
          if (dir == DIR_UP) begin
            if (level < eff_peak) level_n = level + 1'b1;
            else                  dir_n   = DIR_DN;
          end else begin
            if (level != '0) level_n = level - 1'b1;
            else             dir_n   = DIR_UP;
          end
        end
      end
      default: ;
    endcase
  end

  // Configuration registers, active set and LED drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_p <= MODE_OFF;
      duty_p <= '0;
      dirty  <= 1'b0;
      mode   <= MODE_OFF;
      peak   <= '0;
      level  <= '0;
      dir    <= DIR_UP;
      led    <= 1'b0;
    end else begin
      mode_p <= nxt_mode_p;
      duty_p <= nxt_duty_p;
      dirty  <= boundary ? 1'b0 : upd;
      if (boundary) begin
        mode  <= eff_mode;
        peak  <= peak_n;
        level <= level_n;
        dir   <= dir_n;
      end
      case (mode)
        MODE_OFF: led <= 1'b0;
        MODE_ON:  led <= 1'b1;
        default:  led <= (cnt < level);
      endcase
    end
  end

endmodule

// File: rtl/pwm_glow_multi.sv
// Multi-channel PWM LED driver: shared PWM counter, ramp prescaler,
// boundary tick and config write decode feeding per-channel slices.
module pwm_glow_multi
  import pwm_glow_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int PWM_WIDTH = 8,
  parameter int RAMP_DIV  = 4
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [1:0]                                         cfg_mode,
  input  logic [PWM_WIDTH-1:0]                               cfg_duty,
  output logic [CHANNELS-1:0]                                led,
  output logic                                               period_tick
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PR_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PWM_WIDTH-1:0] CNT_LAST   = '1;
  localparam logic [PWM_WIDTH-1:0] CNT_PRE    = CNT_LAST - PWM_WIDTH'(1);
  localparam logic [PR_W-1:0]      PRESC_LAST = PR_W'(RAMP_DIV - 1);

  logic [PWM_WIDTH-1:0] cnt;
  logic [PR_W-1:0]      presc;
  logic                 boundary;
  logic                 step;
  logic                 in_range;
  mode_t                wr_mode;

  // Boundary/step strobes and write qualification.
  always_comb begin
    boundary = (cnt == CNT_LAST);
    step     = boundary && (presc == PRESC_LAST);
    in_range = (32'(cfg_ch) < 32'(CHANNELS));
    wr_mode  = mode_t'(cfg_mode);
  end

  // Free-running counter, boundary-counting prescaler and registered tick
  // (raised on the edge into cnt == max so it is high during that cycle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      presc       <= '0;
      period_tick <= 1'b0;
    end else begin
      cnt         <= cnt + 1'b1;
      period_tick <= (cnt == CNT_PRE);
      if (boundary) presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_glow_channel #(
      .PWM_WIDTH(PWM_WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .wr       (cfg_we && in_range && (cfg_ch == CH_W'(i))),
      .wr_mode  (wr_mode),
      .wr_duty  (cfg_duty),
      .boundary (boundary),
      .step     (step),
      .cnt      (cnt),
      .led      (led[i])
    );
  end

endmodule
